// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// The state encoding, the requester indices and the default memory size live here.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic CORE   = 1'b0;
  localparam logic LOADER = 1'b1;

  localparam int MEM_BYTES_DEFAULT = 1234;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between core (0) and loader (1): fixed priority by default,
// round-robin with a last-granted register when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic win
);

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Starts as "loader granted last" so the first tie after reset goes to the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= LOADER;
    end else if (take) begin
      last_q <= win;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    win = CORE;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = LOADER;
    end
  end
`else
  always_comb begin
    win = CORE;
    if (req1 && !req0) begin
      win = LOADER;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE samples requests, ACCESS drives one memory cycle.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed core priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

  state_t            state, state_next;
  logic              any_req;
  logic              win;
  logic              win_we;
  logic              win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [ADDR_W:0]   win_end;
  logic              owner;
  logic              acc_we;
  logic              acc_oor;

  assign any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic take;
  assign take = (state == IDLE) && any_req;
`endif

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .clk  (clk),
    .reset(reset),
    .take (take),
`endif
    .req0 (req0),
    .req1 (req1),
    .win  (win)
  );

  // One extra bit on the end address keeps addresses near the top of the range from wrapping into range.
  always_comb begin
    win_we    = (win == LOADER) ? we1    : we0;
    win_addr  = (win == LOADER) ? addr1  : addr0;
    win_wdata = (win == LOADER) ? wdata1 : wdata0;
    win_end   = {1'b0, win_addr} + (ADDR_W + 1)'(8);
    win_oor   = win_end > (ADDR_W + 1)'(MEM_BYTES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All pulses default low each cycle; only the IDLE->ACCESS edge and the ACCESS->IDLE edge raise them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= CORE;
      acc_we     <= 1'b0;
      acc_oor    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      Mem_Addr   <= '0;
      Write_Data <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees the pre-edge values of the others.
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= win;
            acc_we     <= win_we;
            acc_oor    <= win_oor;
            Mem_Addr   <= win_addr;
            Write_Data <= win_wdata;
            MemWrite   <= win_we & ~win_oor;
            MemRead    <= ~win_we & ~win_oor;
            gnt0       <= (win == CORE);
            gnt1       <= (win == LOADER);
            err0       <= (win == CORE) & win_oor;
            err1       <= (win == LOADER) & win_oor;
          end
        end
        ACCESS: begin
          if (!acc_we) begin
            if (owner == CORE) begin
              rdata0  <= acc_oor ? '0 : Read_Data;
              rvalid0 <= 1'b1;
            end else begin
              rdata1  <= acc_oor ? '0 : Read_Data;
              rvalid1 <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a byte-array memory and a
// transaction-level reference model (winner choice, range rule, expected memory image).
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 1234;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic              MemWrite, MemRead;
  logic [DATA_W-1:0] Read_Data;

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic       mem_clear = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_rdata0, exp_rdata1;
`ifdef DMEM_ARB_RR_EN
  bit last;
`endif

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data)
  );

  always #5 clk = ~clk;

  // Attached memory: little-endian doublewords, combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (MemWrite && Mem_Addr <= 64'(MEM_BYTES - 8)) begin
      for (int i = 0; i < 8; i++) mem[int'(Mem_Addr) + i] <= Write_Data[8*i +: 8];
    end
  end

  always_comb begin
    Read_Data = '0;
    if (Mem_Addr <= 64'(MEM_BYTES - 8))
      for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[int'(Mem_Addr) + i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_dw(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a) + i];
    return r;
  endfunction

  function automatic logic [63:0] mem_dw(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[int'(a) + i];
    return r;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  function automatic bit model_pick(input bit p0, input bit p1);
    if (p0 && !p1) return 1'b0;
    if (p1 && !p0) return 1'b1;
`ifdef DMEM_ARB_RR_EN
    return !last;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES + 4));
      1:       return 64'hFFFF_FFFF_FFFF_FFF9;
      default: return 64'($urandom_range(0, MEM_BYTES - 8));
    endcase
  endfunction

  // Presents one or two requests and follows them until both are served.
  task automatic run_round(input bit r0, input bit w0, input logic [63:0] a0, input logic [63:0] d0,
                           input bit r1, input bit w1, input logic [63:0] a1, input logic [63:0] d1);
    bit p0, p1, w, is_we, oor;
    logic [63:0] a, d, v, ca;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    p0 = r0; p1 = r1;
    if (!p0 && !p1) begin
      @(posedge clk); #1;
      check("idle_gnt", {gnt0, gnt1}, 0);
      check("idle_strobe", {MemWrite, MemRead}, 0);
      return;
    end
    while (p0 || p1) begin
      w     = model_pick(p0, p1);
      is_we = w ? w1 : w0;
      a     = w ? a1 : a0;
      d     = w ? d1 : d0;
      oor   = a > 64'(MEM_BYTES - 8);
      @(posedge clk); #1;
      check("gnt0", gnt0, w == 1'b0);
      check("gnt1", gnt1, w == 1'b1);
      check("err0", err0, (w == 1'b0) && oor);
      check("err1", err1, (w == 1'b1) && oor);
      check("MemWrite", MemWrite, is_we && !oor);
      check("MemRead", MemRead, !is_we && !oor);
      check("Mem_Addr", Mem_Addr, a);
      if (is_we) check("Write_Data", Write_Data, d);
      check("acc_rvalid", {rvalid0, rvalid1}, 0);
      if (w) begin req1 = 1'b0; p1 = 1'b0; end
      else   begin req0 = 1'b0; p0 = 1'b0; end
`ifdef DMEM_ARB_RR_EN
      last = w;
`endif
      if (!is_we) begin
        v = oor ? 64'd0 : ref_dw(a);
        if (w) exp_rdata1 = v; else exp_rdata0 = v;
      end else if (!oor) begin
        ref_store(a, d);
      end
      @(posedge clk); #1;
      check("rvalid0", rvalid0, (w == 1'b0) && !is_we);
      check("rvalid1", rvalid1, (w == 1'b1) && !is_we);
      check("rdata0", rdata0, exp_rdata0);
      check("rdata1", rdata1, exp_rdata1);
      check("done_pulses", {gnt0, gnt1, err0, err1, MemWrite, MemRead}, 0);
      if (is_we) begin
        ca = oor ? 64'(MEM_BYTES - 8) : a;
        check("mem_image", mem_dw(ca), ref_dw(ca));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    exp_rdata0 = '0; exp_rdata1 = '0;
`ifdef DMEM_ARB_RR_EN
    last = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    check("rst_pulses", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, MemWrite, MemRead}, 0);
    check("rst_Mem_Addr", Mem_Addr, 0);
    check("rst_Write_Data", Write_Data, 0);
    check("rst_rdata", rdata0 | rdata1, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Directed: loader write, core read-back, tie, range boundary, wrap-around address.
    run_round(0, 0, 0, 0, 1, 1, 64'd256, 64'h5);
    check("byte256", mem[256], 8'h05);
    run_round(1, 0, 64'd256, 0, 0, 0, 0, 0);
    run_round(1, 1, 64'd512, 64'h1111_2222_3333_4444, 1, 1, 64'd520, 64'h5555_6666_7777_8888);
    run_round(1, 1, 64'd1227, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 0);
    run_round(1, 0, 64'd1227, 0, 0, 0, 0, 0);
    run_round(1, 1, 64'd1226, 64'h0102_0304_0506_0708, 0, 0, 0, 0);
    run_round(0, 0, 0, 0, 1, 0, 64'd1226, 0);
    run_round(0, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 0);

    for (int n = 0; n < 80; n++) begin
      run_round($urandom_range(0, 1), $urandom_range(0, 1), rand_addr(), {$urandom, $urandom},
                $urandom_range(0, 1), $urandom_range(0, 1), rand_addr(), {$urandom, $urandom});
    end

    // Reset in the middle of a write access must abort it cleanly.
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd264; wdata0 = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    check("abort_pre_MemWrite", MemWrite, 1);
    check("abort_pre_gnt0", gnt0, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_MemWrite", MemWrite, 0);
    check("abort_gnt", {gnt0, gnt1, err0, err1}, 0);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("abort_byte264", mem[264], ref_mem[264]);
    check("abort_dw264", mem_dw(64'd264), ref_dw(64'd264));
    @(negedge clk) reset = 1'b1;
    exp_rdata0 = '0; exp_rdata1 = '0;
`ifdef DMEM_ARB_RR_EN
    last = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", {gnt0, gnt1, rvalid0, rvalid1, MemWrite, MemRead}, 0);
    end
    check("post_rst_rdata0", rdata0, 0);
    run_round(1, 0, 64'd256, 0, 1, 0, 64'd264, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
